video_counter: RTL and testbench

Free-running raster counter for the 800x600@60 SVGA timing path. It advances a horizontal pixel count on every pixel-enable cycle and a vertical line count at each line wrap. It emits `hCount`/`vCount` plus line and frame strobes. It sits directly upstream of the horizontal and vertical sync generators, which decode the counts into visible and sync signals. Those generators feed `vRst`/`hRst` back for resynchronisation.

---
 rtl/video_timing_pkg.sv | 26 ++
 rtl/mod_counter.sv | 27 ++
 rtl/video_counter.sv | 66 ++++++
 tb/tb_video_counter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared 800x600@60 SVGA raster constants and types, common to the raster
// counter and the downstream sync generators.
package video_timing_pkg;

    localparam int H_VISIBLE    = 800;
    localparam int H_SYNC_START = 840;
    localparam int H_SYNC_END   = 968;
    localparam int H_TOTAL      = 1056;

    localparam int V_VISIBLE    = 600;
    localparam int V_SYNC_START = 601;
    localparam int V_SYNC_END   = 605;
    localparam int V_TOTAL      = 628;

    localparam int HC_W = 11;
    localparam int VC_W = 10;

    typedef logic [HC_W-1:0] hCount_t;
    typedef logic [VC_W-1:0] vCount_t;

    typedef struct packed {
        logic lineEnd;
        logic frameStart;
    } strobes_t;

endpackage

// File: rtl/mod_counter.sv
// Enabled modulo counter: wraps to 0 after TERM, on clr, or from any
// out-of-range value, and flags the wrap combinationally in the same cycle.
module mod_counter #(
    parameter int W    = 11,
    parameter int TERM = 1055
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] TERM_V = W'(TERM);

    // >= rather than == so a corrupted count recovers on its next step
    assign wrap = en && (clr || (count >= TERM_V));

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + W'(1);
    end

endmodule

// File: rtl/video_counter.sv
// Free-running raster counter: pixel/line counts, line and frame strobes,
// and a completed-frame counter, with hRst/vRst resynchronisation.
module video_counter #(
    parameter int H_TOTAL = video_timing_pkg::H_TOTAL,
    parameter int V_TOTAL = video_timing_pkg::V_TOTAL,
    parameter int FC_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pixEn,
    input  logic            hRst,
    input  logic            vRst,
    output logic [10:0]     hCount,
    output logic [9:0]      vCount,
    output logic            lineEnd,
    output logic            frameStart,
    output logic [FC_W-1:0] frameCount
);

    import video_timing_pkg::*;

    logic     lineAdv;
    logic     frameAdv;
    strobes_t strobes;

    mod_counter #(
        .W    (HC_W),
        .TERM (H_TOTAL - 1)
    ) uHCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (pixEn),
        .clr   (hRst),
        .count (hCount),
        .wrap  (lineAdv)
    );

    // vRst only matters on line-advance cycles since en gates the clear
    mod_counter #(
        .W    (VC_W),
        .TERM (V_TOTAL - 1)
    ) uVCnt (
        .clk   (clk),
        .rst   (rst),
        .en    (lineAdv),
        .clr   (vRst),
        .count (vCount),
        .wrap  (frameAdv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            strobes    <= '0;
            frameCount <= '0;
        end else begin
            strobes.lineEnd    <= lineAdv;
            strobes.frameStart <= frameAdv;
            if (frameAdv)
                frameCount <= frameCount + FC_W'(1);
        end
    end

    assign lineEnd    = strobes.lineEnd;
    assign frameStart = strobes.frameStart;

endmodule

// File: tb/tb_video_counter.sv
// Scoreboard bench for video_counter using a linear in-frame pixel position
// model; a small raster keeps whole frames and frame-counter wrap short.
module tb_video_counter;

    localparam int H    = 24;
    localparam int V    = 10;
    localparam int FC_W = 8;

    logic            clk = 0;
    logic            rst, pixEn, hRst, vRst;
    logic [10:0]     hCount;
    logic [9:0]      vCount;
    logic            lineEnd, frameStart;
    logic [FC_W-1:0] frameCount;

    video_counter #(.H_TOTAL(H), .V_TOTAL(V), .FC_W(FC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pixEn      (pixEn),
        .hRst       (hRst),
        .vRst       (vRst),
        .hCount     (hCount),
        .vCount     (vCount),
        .lineEnd    (lineEnd),
        .frameStart (frameStart),
        .frameCount (frameCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int le;
        int fs;
        int fc;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    bit   started = 0;

    // Reference model: position is the linear pixel index within the frame
    int pos = 0;
    int fc  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic pe, input logic hr, input logic vr);
        exp_t e;
        int   nxt;
        rst = r; pixEn = pe; hRst = hr; vRst = vr;
        e.le = 0; e.fs = 0;
        if (r) begin
            pos = 0; fc = 0;
        end else if (pe) begin
            nxt = hr ? ((pos / H) + 1) * H : pos + 1;
            if (nxt % H == 0) begin
                e.le = 1;
                if (vr || nxt >= H * V) begin
                    e.fs = 1;
                    nxt  = 0;
                    fc   = (fc + 1) % (1 << FC_W);
                end
            end
            pos = nxt;
        end
        e.h = pos % H; e.v = pos / H; e.fc = fc;
        expQ.push_back(e);
        started = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic runTo(input int h, input int v);
        for (int i = 0; i < 4 * H * V && !(pos % H == h && pos / H == v); i++)
            step(0, 1, 0, 0);
    endtask

    // Monitor: one expected output set per clock edge
    always @(posedge clk) begin
        #1;
        if (started && expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("hCount",     int'(hCount),     e.h);
            chk("vCount",     int'(vCount),     e.v);
            chk("lineEnd",    int'(lineEnd),    e.le);
            chk("frameStart", int'(frameStart), e.fs);
            chk("frameCount", int'(frameCount), e.fc);
        end
    end

    initial begin
        // Reset held 3 clks with pixEn high, then release
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        // Free run: two full frames plus a bit
        for (int i = 0; i < 2 * H * V + 5; i++) step(0, 1, 0, 0);
        // pixEn toggling: counts hold on low cycles, strobes stay 1 clk
        for (int i = 0; i < 4 * H; i++) step(0, i[0] == 0, 0, 0);
        // hRst mid-line, with vRst on the same cycle mid-frame
        runTo(H / 2, V / 2);
        step(0, 1, 1, 0);
        runTo(H / 2, V / 2 + 2);
        step(0, 1, 1, 1);
        // vRst alone off a line boundary is ignored
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1);
        // Simultaneous wrap with both restarts
        runTo(H - 1, V - 1);
        step(0, 1, 1, 1);
        // Frame counter wrap: every cycle a frame advance
        for (int i = 0; i < 260; i++) step(0, 1, 1, 1);
        // Reset mid-frame, then a full frame to the next boundary
        runTo(H / 2 + 3, V / 2 + 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < H * V + 3; i++) step(0, 1, 0, 0);
        // Randomised traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(99) == 0, $urandom_range(9) < 7,
                 $urandom_range(19) == 0, $urandom_range(9) == 0);
        rst = 0; pixEn = 0; hRst = 0; vRst = 0;
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
